// File: rtl/multi_edge_debounce_pkg.sv
// Shared constants and counter-width helpers for the multi-channel input debouncer.
// Board defaults assume a 100 MHz system clock.
package multi_edge_debounce_pkg;

   // 5 ms debounce window and 1 s long-press at 100 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;
   localparam int DEFAULT_HOLD_CYCLES     = 100_000_000;

   function automatic int debounceCntWidth(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

   function automatic int holdCntWidth(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/multi_edge_debounce_if.sv
// Raw inputs and clean event outputs of the debouncer, bundled for the control FSM side.
// master drives the raw inputs; slave is the debouncer itself.
interface multi_edge_debounce_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] signal_in;
   logic [CHANNELS-1:0] level;
   logic [CHANNELS-1:0] pos_edge;
   logic [CHANNELS-1:0] neg_edge;
   logic [CHANNELS-1:0] hold;

   modport master (
      output signal_in,
      input  level,
      input  pos_edge,
      input  neg_edge,
      input  hold
   );

   modport slave (
      input  signal_in,
      output level,
      output pos_edge,
      output neg_edge,
      output hold
   );
endinterface

// File: rtl/multi_edge_debounce_channel.sv
// One input channel: synchroniser, debounce counter, level/edge registers and optional
// long-press counter. Polarity inversion is applied only after the last sync stage.
module debounce_channel
   import multi_edge_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 0,
   parameter bit INVERT          = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic signalIn_i,
   output logic level_o,
   output logic posEdge_o,
   output logic negEdge_o,
   output logic hold_o
);

   localparam int                CNT_W    = debounceCntWidth(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] syncChain_q;
   logic                   synced;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   posEdge_q, posEdge_d;
   logic                   negEdge_q, negEdge_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncChain_q <= '0;
      end else begin
         syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], signalIn_i};
      end
   end

   assign synced = syncChain_q[SYNC_STAGES-1] ^ INVERT;

   // Any sample agreeing with the current level restarts the stability window
   always_comb begin
      cnt_d     = '0;
      level_d   = level_q;
      posEdge_d = 1'b0;
      negEdge_d = 1'b0;
      if (synced != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d   = synced;
            posEdge_d = synced;
            negEdge_d = ~synced;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         level_q   <= 1'b0;
         posEdge_q <= 1'b0;
         negEdge_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         posEdge_q <= posEdge_d;
         negEdge_q <= negEdge_d;
      end
   end

   assign level_o   = level_q;
   assign posEdge_o = posEdge_q;
   assign negEdge_o = negEdge_q;

   generate
      if (HOLD_CYCLES > 0) begin : gHold
         localparam int             HW       = holdCntWidth(HOLD_CYCLES);
         localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_CYCLES);

         logic [HW-1:0] hcnt_q, hcnt_d;
         logic          hold_q, hold_d;

         // Saturating at HOLD_MAX is what limits the pulse to once per press
         always_comb begin
            hcnt_d = '0;
            hold_d = 1'b0;
            if (level_q) begin
               hcnt_d = hcnt_q;
               if (hcnt_q != HOLD_MAX) begin
                  hcnt_d = hcnt_q + 1'b1;
                  hold_d = (hcnt_d == HOLD_MAX);
               end
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               hcnt_q <= '0;
               hold_q <= 1'b0;
            end else begin
               hcnt_q <= hcnt_d;
               hold_q <= hold_d;
            end
         end

         assign hold_o = hold_q;
      end else begin : gNoHold
         assign hold_o = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/multi_edge_debounce.sv
// N-channel synchroniser/debouncer producing clean level plus single-cycle press,
// release and long-press events for the recorder control FSM.
module multi_edge_debounce
   import multi_edge_debounce_pkg::*;
#(
   parameter int                  CHANNELS        = 4,
   parameter int                  SYNC_STAGES     = 2,
   parameter int                  DEBOUNCE_CYCLES = 16,
   parameter int                  HOLD_CYCLES     = 0,
   parameter logic [CHANNELS-1:0] ACTIVE_LOW      = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   multi_edge_debounce_if.slave  bus
);

   logic [CHANNELS-1:0] levelVec;
   logic [CHANNELS-1:0] posEdgeVec;
   logic [CHANNELS-1:0] negEdgeVec;
   logic [CHANNELS-1:0] holdVec;

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : gChan
         debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .INVERT          (ACTIVE_LOW[i])
         ) uChan (
            .clk        (clk),
            .rst        (rst),
            .signalIn_i (bus.signal_in[i]),
            .level_o    (levelVec[i]),
            .posEdge_o  (posEdgeVec[i]),
            .negEdge_o  (negEdgeVec[i]),
            .hold_o     (holdVec[i])
         );
      end
   endgenerate

   assign bus.level    = levelVec;
   assign bus.pos_edge = posEdgeVec;
   assign bus.neg_edge = negEdgeVec;
   assign bus.hold     = holdVec;

endmodule

// File: tb/tb_multi_edge_debounce.sv
// Directed bench for multi_edge_debounce: 4 channels, 2 sync stages, 4-cycle debounce,
// 20-cycle long press, channel 1 active-low. Inputs change and outputs are read on negedges.
module tb_multi_edge_debounce;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   multi_edge_debounce_if #(.CHANNELS(4)) bus ();

   multi_edge_debounce #(
      .CHANNELS        (4),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (20),
      .ACTIVE_LOW      (4'b0010)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [3:0] v);
      bus.signal_in = v;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic [3:0] lv, input logic [3:0] pe,
                           input logic [3:0] ne, input logic [3:0] ho);
      checkOutput({tag, ".level"},    bus.level,    lv);
      checkOutput({tag, ".pos_edge"}, bus.pos_edge, pe);
      checkOutput({tag, ".neg_edge"}, bus.neg_edge, ne);
      checkOutput({tag, ".hold"},     bus.hold,     ho);
   endtask

   // Channel 1 is active-low, so its idle raw value is 1 throughout
   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      applyStimulus(4'b0010);
      tick(2);
      checkAll("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      rst = 1'b0;
      tick(4);
      checkAll("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      $display("[TB] clean press on ch0");
      applyStimulus(4'b0011);
      tick(5);
      checkAll("press_early", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      tick(1);
      checkAll("press_edge", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      tick(1);
      checkAll("press_after", 4'b0001, 4'b0000, 4'b0000, 4'b0000);

      $display("[TB] release on ch0");
      applyStimulus(4'b0010);
      tick(5);
      checkAll("release_early", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      tick(1);
      checkAll("release_edge", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
      tick(1);
      checkAll("release_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      $display("[TB] bouncing press on ch0");
      for (int i = 0; i < 4; i++) begin
         applyStimulus((i % 2 == 0) ? 4'b0011 : 4'b0010);
         tick(2);
         checkAll("bounce", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      end
      applyStimulus(4'b0011);
      tick(5);
      checkAll("bounce_early", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      tick(1);
      checkAll("bounce_edge", 4'b0001, 4'b0001, 4'b0000, 4'b0000);

      $display("[TB] long press on ch0");
      tick(19);
      checkAll("hold_early", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      tick(1);
      checkAll("hold_pulse", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      tick(1);
      checkAll("hold_after", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      tick(15);
      checkAll("hold_once", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      applyStimulus(4'b0010);
      tick(6);
      checkAll("hold_release", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
      applyStimulus(4'b0011);
      tick(6);
      checkAll("repress_edge", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      tick(19);
      checkAll("repress_early", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      tick(1);
      checkAll("repress_hold", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      applyStimulus(4'b0010);
      tick(6);
      checkAll("repress_release", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
      tick(2);

      $display("[TB] simultaneous press with active-low ch1");
      applyStimulus(4'b0001);
      tick(5);
      checkAll("multi_early", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      tick(1);
      checkAll("multi_edge", 4'b0011, 4'b0011, 4'b0000, 4'b0000);
      tick(1);
      checkAll("multi_after", 4'b0011, 4'b0000, 4'b0000, 4'b0000);
      applyStimulus(4'b0010);
      tick(6);
      checkAll("multi_release", 4'b0000, 4'b0000, 4'b0011, 4'b0000);
      tick(1);

      $display("[TB] short glitch on ch2");
      applyStimulus(4'b0110);
      tick(3);
      applyStimulus(4'b0010);
      tick(8);
      checkAll("glitch", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      $display("[TB] reset mid-debounce");
      applyStimulus(4'b0011);
      tick(4);
      rst = 1'b1;
      tick(1);
      checkAll("rst_debounce", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      applyStimulus(4'b0010);
      tick(1);
      rst = 1'b0;
      tick(8);
      checkAll("rst_debounce_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      $display("[TB] reset mid-hold with input still active");
      applyStimulus(4'b0011);
      tick(6);
      checkAll("midhold_press", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      tick(10);
      checkAll("midhold_level", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      #2 rst = 1'b1;
      #1;
      checkAll("rst_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      tick(5);
      checkAll("refresh_early", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      tick(1);
      checkAll("refresh_edge", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
